// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants, slot record and scan FSM states
// Purpose: common definitions for sprite_engine and sprite_slot_cmp.
//   NUM_SPR  number of entries in the sprite position/visibility table
//   X_W/Y_W  pixel X / line Y widths, ID_W sprite index width
//   slot_t   one per-line sprite slot: {valid, id, x, row}
//   state_t  scan FSM states
package sprite_pkg;

  localparam int NUM_SPR = 32;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int ID_W    = 5;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [X_W-1:0]  x;
    logic [3:0]      row;
  } slot_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sprite_slot_cmp.sv
// rtl/sprite_slot_cmp.sv - X-range compare for one loaded sprite slot
// Purpose: decides whether the current pixel falls inside a slot's sprite.
// Ports:
//   valid_i  slot holds a sprite for this line
//   x_i      sprite left edge
//   pix_x_i  current pixel X
//   hit_o    pixel covered (pix_x >= x and pix_x - x < SPR_SIZE)
//   col_o    texel column within the sprite
module sprite_slot_cmp
  import sprite_pkg::*;
#(
  parameter int SPR_SIZE = 16
) (
  input  logic [0:0]     valid_i,
  input  logic [X_W-1:0] x_i,
  input  logic [X_W-1:0] pix_x_i,
  output logic [0:0]     hit_o,
  output logic [3:0]     col_o
);

  localparam logic [X_W-1:0] SIZE_X = X_W'(SPR_SIZE);

  logic [X_W-1:0] d;

  // The pix_x >= x term keeps the subtraction from wrapping into a false hit.
  assign d     = pix_x_i - x_i;
  assign hit_o = valid_i & (pix_x_i >= x_i) & (d < SIZE_X);
  assign col_o = d[3:0];

endmodule

// File: rtl/sprite_engine.sv
// rtl/sprite_engine.sv - sprite table, per-line scan and per-pixel hit render
// Purpose: holds a 32-entry position/visibility table, scans it in hblank
// into MAX_PER_LINE slots, and reports per-pixel sprite hits one cycle late.
// Ports:
//   clk, reset                 pixel clock, async active-low reset
//   sprite_x/y/sel/pos         position write (pos_x/pos_y[sel])
//   sprite_attr/vis            visibility write (vis[sel])
//   line_start, next_y         start a scan for line next_y
//   de, pix_x                  active video enable and current pixel
//   coll_clr                   clears the collision flag
//   spr_hit/id/col/row         registered winning sprite for previous pixel
//   scan_busy                  FSM is in SCAN
//   overflow                   too many sprites matched the current line
//   collision                  sticky two-slot overlap flag
// Build option: SPRITE_COLLIDE_EN enables collision detection; otherwise
// collision is tied low and coll_clr is ignored.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int SPR_SIZE     = 16,
  parameter int MAX_PER_LINE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [X_W-1:0]  sprite_x,
  input  logic [Y_W-1:0]  sprite_y,
  input  logic [ID_W-1:0] sprite_sel,
  input  logic            sprite_pos,
  input  logic            sprite_attr,
  input  logic            sprite_vis,
  input  logic            line_start,
  input  logic [Y_W-1:0]  next_y,
  input  logic            de,
  input  logic [X_W-1:0]  pix_x,
  input  logic            coll_clr,
  output logic            spr_hit,
  output logic [ID_W-1:0] spr_id,
  output logic [3:0]      spr_col,
  output logic [3:0]      spr_row,
  output logic            scan_busy,
  output logic            overflow,
  output logic            collision
);

  localparam logic [Y_W-1:0]  SIZE_Y   = Y_W'(SPR_SIZE);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_SPR - 1);

  // ---------------- sprite table ----------------
  logic [X_W-1:0]     pos_x_q [NUM_SPR];
  logic [Y_W-1:0]     pos_y_q [NUM_SPR];
  logic [NUM_SPR-1:0] vis_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_SPR; k++) begin
        pos_x_q[k] <= '0;
        pos_y_q[k] <= '0;
      end
      vis_q <= '0;
    end else begin
      if (sprite_pos) begin
        pos_x_q[sprite_sel] <= sprite_x;
        pos_y_q[sprite_sel] <= sprite_y;
      end
      if (sprite_attr) begin
        vis_q[sprite_sel] <= sprite_vis;
      end
    end
  end

  // ---------------- scan FSM ----------------
  state_t          state_q, state_d;
  logic [ID_W-1:0] idx_q, idx_d;
  logic [Y_W-1:0]  line_q, line_d;
  slot_t           slots_q [MAX_PER_LINE];
  slot_t           slots_d [MAX_PER_LINE];
  logic            ovf_q, ovf_d;
  logic [Y_W-1:0]  dy;
  logic            match;
  logic            taken;

  // Table is read combinationally, so a write landing on this edge is missed.
  assign dy    = line_q - pos_y_q[idx_q];
  assign match = (state_q == SCAN) & vis_q[idx_q] &
                 (line_q >= pos_y_q[idx_q]) & (dy < SIZE_Y);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    line_d  = line_q;
    case (state_q)
      IDLE:    if (line_start) state_d = SCAN;
      SCAN:    if (line_start) state_d = SCAN;
               else if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (line_start) state_d = SCAN;
      default: state_d = IDLE;
    endcase
    if (line_start) begin
      idx_d  = '0;
      line_d = next_y;
    end else if (state_q == SCAN) begin
      idx_d = idx_q + ID_W'(1);
    end
  end

  // Slots fill lowest-first, so slot order equals ascending sprite id.
  always_comb begin
    slots_d = slots_q;
    ovf_d   = ovf_q;
    taken   = 1'b0;
    if (line_start) begin
      for (int k = 0; k < MAX_PER_LINE; k++) slots_d[k] = '0;
      ovf_d = 1'b0;
    end else if (match) begin
      for (int k = 0; k < MAX_PER_LINE; k++) begin
        if (!slots_q[k].valid && !taken) begin
          slots_d[k].valid = 1'b1;
          slots_d[k].id    = idx_q;
          slots_d[k].x     = pos_x_q[idx_q];
          slots_d[k].row   = dy[3:0];
          taken            = 1'b1;
        end
      end
      if (!taken) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      line_q  <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < MAX_PER_LINE; k++) slots_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      ovf_q   <= ovf_d;
      slots_q <= slots_d;
    end
  end

  assign scan_busy = (state_q == SCAN);
  assign overflow  = ovf_q;

  // ---------------- render ----------------
  logic [MAX_PER_LINE-1:0] slot_hit;
  logic [3:0]              slot_col [MAX_PER_LINE];

  for (genvar g = 0; g < MAX_PER_LINE; g++) begin : g_cmp
    sprite_slot_cmp #(.SPR_SIZE(SPR_SIZE)) u_cmp (
      .valid_i (slots_q[g].valid),
      .x_i     (slots_q[g].x),
      .pix_x_i (pix_x),
      .hit_o   (slot_hit[g]),
      .col_o   (slot_col[g])
    );
  end

  logic            active;
  logic            any_hit;
  logic [ID_W-1:0] win_id;
  logic [3:0]      win_col, win_row;

  assign active = de & ~scan_busy;

  // Descending walk so the lowest hitting slot is the last one written.
  always_comb begin
    any_hit = 1'b0;
    win_id  = '0;
    win_col = '0;
    win_row = '0;
    for (int k = MAX_PER_LINE - 1; k >= 0; k--) begin
      if (slot_hit[k]) begin
        any_hit = 1'b1;
        win_id  = slots_q[k].id;
        win_col = slot_col[k];
        win_row = slots_q[k].row;
      end
    end
  end

  logic            hit_q, hit_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [3:0]      col_q, col_d, row_q, row_d;

  always_comb begin
    hit_d = 1'b0;
    id_d  = '0;
    col_d = '0;
    row_d = '0;
    if (active && any_hit) begin
      hit_d = 1'b1;
      id_d  = win_id;
      col_d = win_col;
      row_d = win_row;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q <= 1'b0;
      id_q  <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      hit_q <= hit_d;
      id_q  <= id_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign spr_hit = hit_q;
  assign spr_id  = id_q;
  assign spr_col = col_q;
  assign spr_row = row_q;

  // ---------------- collision ----------------
`ifdef SPRITE_COLLIDE_EN
  localparam int CNT_W = $clog2(MAX_PER_LINE + 1);

  logic [CNT_W-1:0] hit_cnt;
  logic             coll_q, coll_d;

  always_comb begin
    hit_cnt = '0;
    for (int k = 0; k < MAX_PER_LINE; k++) hit_cnt = hit_cnt + CNT_W'(slot_hit[k]);
  end

  // A new collision outranks a simultaneous clear.
  always_comb begin
    coll_d = coll_q;
    if (active && (hit_cnt >= CNT_W'(2))) coll_d = 1'b1;
    else if (coll_clr)                    coll_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) coll_q <= 1'b0;
    else        coll_q <= coll_d;
  end

  assign collision = coll_q;
`else
  logic unused_coll_clr;
  assign unused_coll_clr = coll_clr;
  assign collision       = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_engine.sv
// tb/tb_sprite_engine.sv - directed self-checking bench for sprite_engine
module tb_sprite_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] sprite_x = '0;
  logic [8:0] sprite_y = '0;
  logic [4:0] sprite_sel = '0;
  logic       sprite_pos = 1'b0;
  logic       sprite_attr = 1'b0;
  logic       sprite_vis = 1'b0;
  logic       line_start = 1'b0;
  logic [8:0] next_y = '0;
  logic       de = 1'b0;
  logic [9:0] pix_x = '0;
  logic       coll_clr = 1'b0;
  logic       spr_hit;
  logic [4:0] spr_id;
  logic [3:0] spr_col;
  logic [3:0] spr_row;
  logic       scan_busy;
  logic       overflow;
  logic       collision;

`ifdef SPRITE_COLLIDE_EN
  localparam logic COLL = 1'b1;
`else
  localparam logic COLL = 1'b0;
`endif

  sprite_engine #(.SPR_SIZE(16), .MAX_PER_LINE(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .sprite_sel  (sprite_sel),
    .sprite_pos  (sprite_pos),
    .sprite_attr (sprite_attr),
    .sprite_vis  (sprite_vis),
    .line_start  (line_start),
    .next_y      (next_y),
    .de          (de),
    .pix_x       (pix_x),
    .coll_clr    (coll_clr),
    .spr_hit     (spr_hit),
    .spr_id      (spr_id),
    .spr_col     (spr_col),
    .spr_row     (spr_row),
    .scan_busy   (scan_busy),
    .overflow    (overflow),
    .collision   (collision)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_spr(input int sel, input int x, input int y, input logic vis);
    sprite_sel  = 5'(sel);
    sprite_x    = 10'(x);
    sprite_y    = 9'(y);
    sprite_vis  = vis;
    sprite_pos  = 1'b1;
    sprite_attr = 1'b1;
    tick();
    sprite_pos  = 1'b0;
    sprite_attr = 1'b0;
  endtask

  task automatic pulse_line(input int y);
    next_y     = 9'(y);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic scan_line(input int y);
    pulse_line(y);
    repeat (32) tick();
  endtask

  task automatic probe(input int px, input logic clr);
    de       = 1'b1;
    pix_x    = 10'(px);
    coll_clr = clr;
    tick();
    de       = 1'b0;
    pix_x    = '0;
    coll_clr = 1'b0;
  endtask

  task automatic expect_pix(input string tag, input logic h, input int id, input int col, input int row);
    check({tag, ".hit"}, spr_hit, h);
    check({tag, ".id"},  spr_id,  id);
    check({tag, ".col"}, spr_col, col);
    check({tag, ".row"}, spr_row, row);
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    expect_pix("rst", 1'b0, 0, 0, 0);
    check("rst.busy", scan_busy, 0);
    check("rst.ovf",  overflow,  0);
    check("rst.coll", collision, 0);
    reset = 1'b1;
    tick();

    // single sprite, busy window length
    write_spr(3, 100, 50, 1'b1);
    pulse_line(55);
    check("single.busy_first", scan_busy, 1);
    repeat (31) tick();
    check("single.busy_last", scan_busy, 1);
    tick();
    check("single.busy_end", scan_busy, 0);
    probe(104, 1'b0); expect_pix("single.104", 1'b1, 3, 4, 5);
    probe(116, 1'b0); expect_pix("single.116", 1'b0, 0, 0, 0);
    probe(115, 1'b0); expect_pix("single.115", 1'b1, 3, 15, 5);
    probe(99,  1'b0); expect_pix("single.99",  1'b0, 0, 0, 0);
    de = 1'b0; pix_x = 10'd104; tick();
    check("single.de_low", spr_hit, 0);

    // hits are suppressed while scanning even once the slot is loaded
    pulse_line(55);
    repeat (8) tick();
    probe(104, 1'b0);
    check("busy.suppress", spr_hit, 0);
    repeat (30) tick();

    // priority and collision
    write_spr(2, 200, 10, 1'b1);
    write_spr(7, 200, 10, 1'b1);
    scan_line(10);
    probe(205, 1'b0); expect_pix("prio.205", 1'b1, 2, 5, 0);
    check("coll.set", collision, COLL);
    probe(300, 1'b0);
    check("coll.sticky", collision, COLL);
    coll_clr = 1'b1; tick(); coll_clr = 1'b0;
    check("coll.clr", collision, 0);
    probe(205, 1'b1);
    check("coll.set_wins", collision, COLL);
    coll_clr = 1'b1; tick(); coll_clr = 1'b0;

    // overflow: nine sprites on line 20
    for (int k = 0; k < 9; k++) write_spr(k, 300 + 20 * k, 20, 1'b1);
    pulse_line(20);
    check("ovf.clear_on_entry", overflow, 0);
    repeat (32) tick();
    check("ovf.set", overflow, 1);
    probe(441, 1'b0); expect_pix("ovf.slot7", 1'b1, 7, 1, 0);
    probe(461, 1'b0); expect_pix("ovf.dropped8", 1'b0, 0, 0, 0);
    probe(301, 1'b0); expect_pix("ovf.slot0", 1'b1, 0, 1, 0);
    check("ovf.hold", overflow, 1);
    scan_line(40);
    check("ovf.cleared", overflow, 0);
    probe(301, 1'b0);
    check("ovf.empty_line", spr_hit, 0);

    // reset mid-scan
    pulse_line(20);
    repeat (5) tick();
    check("rstmid.busy_before", scan_busy, 1);
    reset = 1'b0;
    #1;
    check("rstmid.busy", scan_busy, 0);
    check("rstmid.ovf",  overflow,  0);
    check("rstmid.hit",  spr_hit,   0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("rstmid.idle", scan_busy, 0);
    probe(100, 1'b0); expect_pix("rstmid.100", 1'b0, 0, 0, 0);

    // vertical boundaries
    write_spr(5, 50, 500, 1'b1);
    write_spr(6, 150, 0, 1'b1);
    scan_line(4);
    probe(55, 1'b0);  check("bnd.nowrap", spr_hit, 0);
    probe(151, 1'b0); expect_pix("bnd.y4", 1'b1, 6, 1, 4);
    scan_line(15);
    probe(151, 1'b0); expect_pix("bnd.y15", 1'b1, 6, 1, 15);
    scan_line(16);
    probe(151, 1'b0); check("bnd.y16", spr_hit, 0);

    // restart at scan cycle 10, and a write to entry 0 after it was scanned
    pulse_line(5);
    repeat (9) tick();
    pulse_line(5);
    repeat (5) tick();
    write_spr(0, 150, 0, 1'b1);
    repeat (25) tick();
    check("restart.busy_last", scan_busy, 1);
    tick();
    check("restart.busy_end", scan_busy, 0);
    probe(151, 1'b0); expect_pix("race.same_line", 1'b1, 6, 1, 5);
    scan_line(5);
    probe(151, 1'b0); expect_pix("race.next_line", 1'b1, 0, 1, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
